// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/freeze sequencer for the 5-stage MIPS pipeline.
// Arbitrates MemBusy > redirect > flush tail > hazard stall > run, and keeps perf counters and a stall watchdog.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             HazardStall,
  input  logic             BranchTaken,
  input  logic             JumpTaken,
  input  logic             MemBusy,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             PipeFreeze,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             WatchdogErr
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [8:0]       WD_LIMIT     = 9'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       flush_left_q, flush_left_d;
  logic [7:0]       stall_run_q, stall_run_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             watchdog_q, watchdog_d;
  logic             redirect;

  assign redirect = BranchTaken | JumpTaken;

  // Decision and enables are purely combinational so a stall or flush
  // acts in the very cycle it is requested.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skipped one would infer a latch.
    state_d       = ST_RUN;
    flush_left_d  = flush_left_q;
    stall_run_d   = 8'd0;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    watchdog_d    = watchdog_q;
    PCWrite       = 1'b1;
    IFIDWrite     = 1'b1;
    IFIDFlush     = 1'b0;
    IDEXBubble    = 1'b0;
    PipeFreeze    = 1'b0;

    if (Rst) begin
      // Register clearing happens in the state process; only the
      // enable pattern matters here.
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (MemBusy) begin
      // Frozen stages keep presenting any redirect or stall, so nothing is lost.
      state_d     = ST_FREEZE;
      stall_run_d = stall_run_q;
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      PipeFreeze  = 1'b1;
    end else if (redirect) begin
      state_d       = ST_FLUSH;
      flush_left_d  = FLUSH_RELOAD;
      flush_count_d = (flush_count_q == CNT_MAX) ? CNT_MAX : flush_count_q + CNT_ONE;
      IFIDFlush     = 1'b1;
    end else if (flush_left_q != 3'd0) begin
      // ID holds a squashed nop, so any hazard it reports is spurious.
      state_d      = ST_FLUSH;
      flush_left_d = flush_left_q - 3'd1;
      IFIDFlush    = 1'b1;
    end else if (HazardStall) begin
      state_d       = ST_STALL;
      stall_count_d = (stall_count_q == CNT_MAX) ? CNT_MAX : stall_count_q + CNT_ONE;
      stall_run_d   = (stall_run_q == 8'hFF) ? 8'hFF : stall_run_q + 8'd1;
      if (({1'b0, stall_run_q} + 9'd1) == WD_LIMIT) begin
        watchdog_d = 1'b1;
      end
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (Rst) begin
      state_q       <= ST_RUN;
      flush_left_q  <= 3'd0;
      stall_run_q   <= 8'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
      watchdog_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      stall_run_q   <= stall_run_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
      watchdog_q    <= watchdog_d;
    end
  end

  assign State       = state_q;
  assign StallCount  = stall_count_q;
  assign FlushCount  = flush_count_q;
  assign WatchdogErr = watchdog_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (FLUSH_CYCLES=3, MAX_STALL=8, CNT_W=4).
// Table of per-cycle vectors plus hand loops for counter saturation.
`timescale 1ns/1ps
module tb_pipeline_stall_controller;

  localparam int CNT_W = 4;

  localparam logic [4:0] O_RST = 5'b00110;
  localparam logic [4:0] O_FRZ = 5'b00001;
  localparam logic [4:0] O_FLS = 5'b11100;
  localparam logic [4:0] O_STL = 5'b00010;
  localparam logic [4:0] O_RUN = 5'b11000;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             HazardStall = 1'b0;
  logic             BranchTaken = 1'b0;
  logic             JumpTaken = 1'b0;
  logic             MemBusy = 1'b0;
  logic             PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic             WatchdogErr;

  int checks = 0;
  int errors = 0;

  pipeline_stall_controller #(
    .FLUSH_CYCLES(3),
    .MAX_STALL   (8),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .HazardStall(HazardStall),
    .BranchTaken(BranchTaken),
    .JumpTaken  (JumpTaken),
    .MemBusy    (MemBusy),
    .PCWrite    (PCWrite),
    .IFIDWrite  (IFIDWrite),
    .IFIDFlush  (IFIDFlush),
    .IDEXBubble (IDEXBubble),
    .PipeFreeze (PipeFreeze),
    .State      (State),
    .StallCount (StallCount),
    .FlushCount (FlushCount),
    .WatchdogErr(WatchdogErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       rst, hs, br, jp, mb;
    logic [4:0] out;
    logic [1:0] st;
    int         sc, fc;
    logic       wd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic r, logic h, logic b, logic j, logic m,
                              logic [4:0] o, logic [1:0] s, int sc, int fc, logic wd);
    vec_t v;
    v.name = n; v.rst = r; v.hs = h; v.br = b; v.jp = j; v.mb = m;
    v.out = o; v.st = s; v.sc = sc; v.fc = fc; v.wd = wd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, leave 1ns for the combinational enables.
  task automatic drive(input logic r, input logic h, input logic b, input logic j, input logic m);
    @(negedge Clk);
    Rst = r; HazardStall = h; BranchTaken = b; JumpTaken = j; MemBusy = m;
    #1;
  endtask

  function automatic logic [4:0] enables();
    return {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze};
  endfunction

  task automatic after_edge();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //   name         rst hs br jp mb  out    st  sc  fc  wd
    add("reset0",     1, 1, 0, 0, 0, O_RST, 0,  0,  0, 0);
    add("reset1",     1, 1, 0, 0, 0, O_RST, 0,  0,  0, 0);
    add("run0",       0, 0, 0, 0, 0, O_RUN, 0,  0,  0, 0);
    add("loaduse",    0, 1, 0, 0, 0, O_STL, 1,  1,  0, 0);
    add("after_ld",   0, 0, 0, 0, 0, O_RUN, 0,  1,  0, 0);
    add("br_flush",   0, 0, 1, 0, 0, O_FLS, 2,  1,  1, 0);
    add("tail1_hs",   0, 1, 0, 0, 0, O_FLS, 2,  1,  1, 0);
    add("tail2_hs",   0, 1, 0, 0, 0, O_FLS, 2,  1,  1, 0);
    add("post_stall", 0, 1, 0, 0, 0, O_STL, 1,  2,  1, 0);
    add("run1",       0, 0, 0, 0, 0, O_RUN, 0,  2,  1, 0);
    add("frz_jp0",    0, 0, 0, 1, 1, O_FRZ, 3,  2,  1, 0);
    add("frz_jp1",    0, 0, 0, 1, 1, O_FRZ, 3,  2,  1, 0);
    add("frz_jp2",    0, 0, 0, 1, 1, O_FRZ, 3,  2,  1, 0);
    add("frz_jp3",    0, 0, 0, 1, 1, O_FRZ, 3,  2,  1, 0);
    add("jp_flush",   0, 0, 0, 1, 0, O_FLS, 2,  2,  2, 0);
    add("jp_tail1",   0, 0, 0, 0, 0, O_FLS, 2,  2,  2, 0);
    add("jp_tail2",   0, 0, 0, 0, 0, O_FLS, 2,  2,  2, 0);
    add("run2",       0, 0, 0, 0, 0, O_RUN, 0,  2,  2, 0);
    add("br_again",   0, 0, 1, 0, 0, O_FLS, 2,  2,  3, 0);
    add("restart",    0, 0, 0, 1, 0, O_FLS, 2,  2,  4, 0);
    add("frz_in_win", 0, 1, 0, 0, 1, O_FRZ, 3,  2,  4, 0);
    add("rs_tail1",   0, 1, 0, 0, 0, O_FLS, 2,  2,  4, 0);
    add("rs_tail2",   0, 1, 0, 0, 0, O_FLS, 2,  2,  4, 0);
    add("run3",       0, 0, 0, 0, 0, O_RUN, 0,  2,  4, 0);
    add("wd_s1",      0, 1, 0, 0, 0, O_STL, 1,  3,  4, 0);
    add("wd_s2",      0, 1, 0, 0, 0, O_STL, 1,  4,  4, 0);
    add("wd_s3",      0, 1, 0, 0, 0, O_STL, 1,  5,  4, 0);
    add("wd_frz",     0, 1, 0, 0, 1, O_FRZ, 3,  5,  4, 0);
    add("wd_s4",      0, 1, 0, 0, 0, O_STL, 1,  6,  4, 0);
    add("wd_s5",      0, 1, 0, 0, 0, O_STL, 1,  7,  4, 0);
    add("wd_s6",      0, 1, 0, 0, 0, O_STL, 1,  8,  4, 0);
    add("wd_s7",      0, 1, 0, 0, 0, O_STL, 1,  9,  4, 0);
    add("wd_s8",      0, 1, 0, 0, 0, O_STL, 1, 10,  4, 1);
    add("wd_s9",      0, 1, 0, 0, 0, O_STL, 1, 11,  4, 1);
    add("wd_sticky",  0, 0, 0, 0, 0, O_RUN, 0, 11,  4, 1);
    add("rst_mid",    1, 1, 0, 0, 0, O_RST, 0,  0,  0, 0);
    add("s7_1",       0, 1, 0, 0, 0, O_STL, 1,  1,  0, 0);
    add("s7_2",       0, 1, 0, 0, 0, O_STL, 1,  2,  0, 0);
    add("s7_3",       0, 1, 0, 0, 0, O_STL, 1,  3,  0, 0);
    add("s7_4",       0, 1, 0, 0, 0, O_STL, 1,  4,  0, 0);
    add("s7_5",       0, 1, 0, 0, 0, O_STL, 1,  5,  0, 0);
    add("s7_6",       0, 1, 0, 0, 0, O_STL, 1,  6,  0, 0);
    add("s7_7",       0, 1, 0, 0, 0, O_STL, 1,  7,  0, 0);
    add("s7_run",     0, 0, 0, 0, 0, O_RUN, 0,  7,  0, 0);
    add("s7_again",   0, 1, 0, 0, 0, O_STL, 1,  8,  0, 0);
    add("s7_brk",     0, 0, 1, 0, 0, O_FLS, 2,  8,  1, 0);
    add("rst_flush",  1, 0, 0, 0, 0, O_RST, 0,  0,  0, 0);
    add("post_rst",   0, 1, 0, 0, 0, O_STL, 1,  1,  0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].hs, vecs[i].br, vecs[i].jp, vecs[i].mb);
      check({vecs[i].name, ".enables"}, 32'(enables()), 32'(vecs[i].out));
      after_edge();
      check({vecs[i].name, ".state"}, 32'(State), 32'(vecs[i].st));
      check({vecs[i].name, ".stallcnt"}, 32'(StallCount), 32'(vecs[i].sc));
      check({vecs[i].name, ".flushcnt"}, 32'(FlushCount), 32'(vecs[i].fc));
      check({vecs[i].name, ".wd"}, 32'(WatchdogErr), 32'(vecs[i].wd));
    end

    // FlushCount saturation: 20 redirects, each followed by its 2-cycle tail.
    drive(1, 0, 0, 0, 0);
    after_edge();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, 0);
      check("sat_fl.enables", 32'(enables()), 32'(O_FLS));
      after_edge();
      check("sat_fl.count", 32'(FlushCount), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      for (int t = 0; t < 2; t++) begin
        drive(0, 0, 0, 0, 0);
        check("sat_fl.tail", 32'(IFIDFlush), 32'd1);
        after_edge();
      end
    end
    drive(0, 0, 0, 0, 0);
    check("sat_fl.run", 32'(enables()), 32'(O_RUN));
    after_edge();
    check("sat_fl.final", 32'(FlushCount), 32'd15);

    // StallCount saturation over a long stall run; watchdog rises on the 8th.
    drive(1, 0, 0, 0, 0);
    after_edge();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 0);
      after_edge();
      check("sat_st.count", 32'(StallCount), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      check("sat_st.wd", 32'(WatchdogErr), (i + 1 >= 8) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0, 0);
    after_edge();
    check("sat_st.final", 32'(StallCount), 32'd15);
    check("sat_st.state", 32'(State), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
